// File: rtl/gcd_pkg.sv
// Shared constants and FSM encoding for the Avalon-MM GCD front end.
// Register map, CTRL bit positions and controller state enum.
package gcd_pkg;

   localparam logic [1:0] ADDR_A      = 2'd0;
   localparam logic [1:0] ADDR_B      = 2'd1;
   localparam logic [1:0] ADDR_CTRL   = 2'd2;
   localparam logic [1:0] ADDR_RESULT = 2'd3;

   localparam int CTRL_START = 0;
   localparam int CTRL_BUSY  = 1;
   localparam int CTRL_DONE  = 2;
   localparam int CTRL_ERR   = 3;
   localparam int CTRL_IE    = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD_A,
      ST_LOAD_B,
      ST_WAIT,
      ST_ABORT
   } gcd_state_e;

endpackage

// File: rtl/gcd_watchdog.sv
// Saturating busy-cycle counter guarding the GCD core wait phase.
// expired_o flags the cycle in which the count reaches TIMEOUT_CYCLES.
module gcd_watchdog #(
   parameter int TIMEOUT_CYCLES = 96
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_o
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && (cnt_q != LIMIT)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   assign expired_o = enable_i && (cnt_d == LIMIT);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/gcd_avalon_if.sv
// Avalon-MM slave wrapping a GCD core: operand shadows, start FSM, watchdog.
// Define GCD_IRQ_EN to add the IE control bit and the irq output.
module gcd_avalon_if
   import gcd_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 96,
   parameter int DATA_W         = 32
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic [1:0]        address,
   input  logic              chipselect,
   input  logic              write,
   input  logic              read,
   input  logic [DATA_W-1:0] writedata,
   output logic [DATA_W-1:0] readdata,
   output logic [DATA_W-1:0] opIn,
   output logic              loadA,
   output logic              loadB,
   output logic              gcd_resetn,
   input  logic [DATA_W-1:0] outGCD,
   input  logic              outDone
`ifdef GCD_IRQ_EN
   ,output logic             irq
`endif
);

   gcd_state_e state_q, state_d;

   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] result_q, result_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [DATA_W-1:0] ctrl_rd;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic              ie_bit;
   logic              wr_en, rd_en, ctrl_wr, start;
   logic              in_idle, in_wait, core_done;
   logic              wd_expired;

   assign wr_en     = chipselect & write;
   assign rd_en     = chipselect & read;
   assign ctrl_wr   = wr_en && (address == ADDR_CTRL);
   assign start     = ctrl_wr && writedata[CTRL_START];
   assign in_idle   = (state_q == ST_IDLE);
   assign in_wait   = (state_q == ST_WAIT);
   assign core_done = in_wait && outDone;

   gcd_watchdog #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_wdog (
      .clk_i    (clock),
      .rst_ni   (resetn),
      .clear_i  (state_q == ST_LOAD_B),
      .enable_i (in_wait),
      .expired_o(wd_expired)
   );

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // A done pulse in the same cycle as expiry still completes normally.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:   if (start) state_d = ST_LOAD_A;
         ST_LOAD_A: state_d = ST_LOAD_B;
         ST_LOAD_B: state_d = ST_WAIT;
         ST_WAIT: begin
            if (outDone) begin
               state_d = ST_IDLE;
            end else if (wd_expired) begin
               state_d = ST_ABORT;
            end
         end
         ST_ABORT:  state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      opIn       = '0;
      loadA      = 1'b0;
      loadB      = 1'b0;
      gcd_resetn = 1'b1;
      unique case (state_q)
         ST_LOAD_A: begin
            opIn  = a_q;
            loadA = 1'b1;
         end
         ST_LOAD_B: begin
            opIn  = b_q;
            loadB = 1'b1;
         end
         ST_ABORT:  gcd_resetn = 1'b0;
         default:   ;
      endcase
   end

   // Sticky flags: a set in the same cycle as the W1C write wins.
   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      done_d   = done_q;
      err_d    = err_q;
      if (wr_en && in_idle && (address == ADDR_A)) a_d = writedata;
      if (wr_en && in_idle && (address == ADDR_B)) b_d = writedata;
      if (ctrl_wr && writedata[CTRL_DONE]) done_d = 1'b0;
      if (ctrl_wr && writedata[CTRL_ERR])  err_d  = 1'b0;
      if (core_done) begin
         result_d = outGCD;
         done_d   = 1'b1;
      end
      if (state_q == ST_ABORT) err_d = 1'b1;
   end

   always_comb begin
      ctrl_rd            = '0;
      ctrl_rd[CTRL_BUSY] = !in_idle;
      ctrl_rd[CTRL_DONE] = done_q;
      ctrl_rd[CTRL_ERR]  = err_q;
      ctrl_rd[CTRL_IE]   = ie_bit;
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         unique case (address)
            ADDR_A:    rdata_d = a_q;
            ADDR_B:    rdata_d = b_q;
            ADDR_CTRL: rdata_d = ctrl_rd;
            default:   rdata_d = result_q;
         endcase
      end
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         rdata_q  <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         rdata_q  <= rdata_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign readdata = rdata_q;

`ifdef GCD_IRQ_EN
   logic ie_q, ie_d;
   logic irq_q, irq_d;

   always_comb begin
      ie_d  = ie_q;
      if (ctrl_wr) ie_d = writedata[CTRL_IE];
      irq_d = ie_q & (done_q | err_q);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         ie_q  <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         ie_q  <= ie_d;
         irq_q <= irq_d;
      end
   end

   assign ie_bit = ie_q;
   assign irq    = irq_q;
`else
   assign ie_bit = 1'b0;
`endif

endmodule

// File: tb/tb_gcd_avalon_if.sv
// Directed bench for gcd_avalon_if with a behavioural GCD core stub.
// Honours GCD_IRQ_EN when defined for the build.
module tb_gcd_avalon_if;

   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic [1:0]  address = 2'd0;
   logic        chipselect = 1'b0;
   logic        write = 1'b0;
   logic        read = 1'b0;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic [31:0] opIn;
   logic        loadA, loadB, gcd_resetn;
   logic [31:0] outGCD;
   logic        outDone;
`ifdef GCD_IRQ_EN
   logic        irq;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clock = ~clock;

   gcd_avalon_if #(
      .TIMEOUT_CYCLES(8),
      .DATA_W(32)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .address   (address),
      .chipselect(chipselect),
      .write     (write),
      .read      (read),
      .writedata (writedata),
      .readdata  (readdata),
      .opIn      (opIn),
      .loadA     (loadA),
      .loadB     (loadB),
      .gcd_resetn(gcd_resetn),
      .outGCD    (outGCD),
      .outDone   (outDone)
`ifdef GCD_IRQ_EN
      ,.irq      (irq)
`endif
   );

   // Core stub: latches operands, answers a few cycles after loadB.
   logic        core_en = 1'b1;
   logic        core_done = 1'b0;
   logic        force_done = 1'b0;
   logic        pend = 1'b0;
   logic [31:0] ca = '0, cb = '0, core_res = '0;
   int          cdly = 0;
   int          nloadA = 0;

   function automatic logic [31:0] gcd(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] a, b, t;
      a = x;
      b = y;
      while (b != 0) begin
         t = b;
         b = a % b;
         a = t;
      end
      return a;
   endfunction

   assign outDone = core_done | force_done;
   assign outGCD  = core_res;

   always @(posedge clock) begin
      core_done <= 1'b0;
      if (loadA === 1'b1) nloadA = nloadA + 1;
      if (gcd_resetn === 1'b0) begin
         pend <= 1'b0;
      end else begin
         if (loadA) ca <= opIn;
         if (loadB) begin
            cb   <= opIn;
            pend <= 1'b1;
            cdly <= 3;
         end else if (pend && core_en) begin
            if (cdly == 0) begin
               core_done <= 1'b1;
               core_res  <= gcd(ca, cb);
               pend      <= 1'b0;
            end else begin
               cdly <= cdly - 1;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      @(negedge clock);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write      = 1'b1;
      @(negedge clock);
      chipselect = 1'b0;
      write      = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      @(negedge clock);
      address    = a;
      chipselect = 1'b1;
      read       = 1'b1;
      @(negedge clock);
      chipselect = 1'b0;
      read       = 1'b0;
      d          = readdata;
   endtask

   task automatic wait_idle(input string tag);
      logic [31:0] v;
      int n;
      n = 0;
      do begin
         bus_read(2'd2, v);
         n++;
      end while (v[1] && n < 40);
      check(tag, {31'd0, v[1]}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "bench timeout");
   end

   initial begin
      logic [31:0] v;
      int k;

      repeat (3) @(negedge clock);
      check("rst_loadA", {31'd0, loadA}, 32'd0);
      check("rst_loadB", {31'd0, loadB}, 32'd0);
      check("rst_opIn", opIn, 32'd0);
      check("rst_gcd_resetn", {31'd0, gcd_resetn}, 32'd1);
      check("rst_readdata", readdata, 32'd0);
      resetn = 1'b1;
      bus_read(2'd2, v);
      check("rst_ctrl", v, 32'd0);
      bus_read(2'd3, v);
      check("rst_result", v, 32'd0);

      // 48/18 -> 6, with load sequencing
      bus_write(2'd0, 32'd48);
      bus_write(2'd1, 32'd18);
      bus_write(2'd2, 32'd1);
      check("t1_loadA", {31'd0, loadA}, 32'd1);
      check("t1_opA", opIn, 32'd48);
      check("t1_loadB_early", {31'd0, loadB}, 32'd0);
      @(negedge clock);
      check("t1_loadB", {31'd0, loadB}, 32'd1);
      check("t1_opB", opIn, 32'd18);
      check("t1_loadA_off", {31'd0, loadA}, 32'd0);
      @(negedge clock);
      check("t1_wait_loadB", {31'd0, loadB}, 32'd0);
      check("t1_wait_op", opIn, 32'd0);
      wait_idle("t1_idle");
      bus_read(2'd3, v);
      check("t1_result", v, 32'd6);
      bus_read(2'd2, v);
      check("t1_ctrl", v, 32'h4);

      // 0/7 and 13/13, then W1C of DONE
      bus_write(2'd0, 32'd0);
      bus_write(2'd1, 32'd7);
      bus_write(2'd2, 32'd1);
      wait_idle("t2a_idle");
      bus_read(2'd3, v);
      check("t2a_result", v, 32'd7);
      bus_write(2'd0, 32'd13);
      bus_write(2'd1, 32'd13);
      bus_write(2'd2, 32'd1);
      wait_idle("t2b_idle");
      bus_read(2'd3, v);
      check("t2b_result", v, 32'd13);
      bus_write(2'd2, 32'h4);
      bus_read(2'd2, v);
      check("t2_w1c_ctrl", v, 32'h0);
      bus_read(2'd3, v);
      check("t2_w1c_result", v, 32'd13);

`ifdef GCD_IRQ_EN
      bus_write(2'd2, 32'h10);
      bus_read(2'd2, v);
      check("t6_ie", v, 32'h10);
      bus_write(2'd0, 32'd26);
      bus_write(2'd1, 32'd13);
      bus_write(2'd2, 32'h11);
      wait_idle("t6_idle");
      check("t6_irq_set", {31'd0, irq}, 32'd1);
      bus_write(2'd2, 32'h14);
      @(negedge clock);
      check("t6_irq_clr", {31'd0, irq}, 32'd0);
      bus_write(2'd2, 32'h0);
`else
      bus_write(2'd2, 32'h10);
      bus_read(2'd2, v);
      check("t6_ie_absent", v, 32'h0);
`endif

      // START and A write during WAIT are ignored
      bus_write(2'd0, 32'd30);
      bus_write(2'd1, 32'd45);
      nloadA = 0;
      bus_write(2'd2, 32'd1);
      @(negedge clock);
      bus_write(2'd2, 32'd1);
      bus_write(2'd0, 32'd99);
      wait_idle("t3_idle");
      check("t3_loadA_count", nloadA, 32'd1);
      bus_read(2'd3, v);
      check("t3_result", v, 32'd15);
      bus_read(2'd0, v);
      check("t3_shadowA", v, 32'd30);

      // Silent core: watchdog abort after 8 WAIT cycles
      bus_write(2'd2, 32'h4);
      core_en = 1'b0;
      bus_write(2'd0, 32'd9);
      bus_write(2'd1, 32'd6);
      bus_write(2'd2, 32'd1);
      @(negedge clock);
      check("t4_loadB", {31'd0, loadB}, 32'd1);
      k = 0;
      while (k < 30 && gcd_resetn !== 1'b0) begin
         @(negedge clock);
         k++;
      end
      check("t4_abort_lat", k, 32'd9);
      @(negedge clock);
      check("t4_rstn_width", {31'd0, gcd_resetn}, 32'd1);
      bus_read(2'd2, v);
      check("t4_ctrl", v, 32'h8);
      bus_read(2'd3, v);
      check("t4_result", v, 32'd15);
      bus_write(2'd2, 32'h8);
      bus_read(2'd2, v);
      check("t4_err_w1c", v, 32'h0);
      core_en = 1'b1;

      // Reset two cycles into WAIT; late done must be ignored
      bus_read(2'd3, v);
      bus_write(2'd0, 32'd20);
      bus_write(2'd1, 32'd8);
      bus_write(2'd2, 32'd1);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      #2 resetn = 1'b0;
      #1;
      check("t5_readdata", readdata, 32'd0);
      check("t5_opIn", opIn, 32'd0);
      check("t5_loadA", {31'd0, loadA}, 32'd0);
      check("t5_loadB", {31'd0, loadB}, 32'd0);
      check("t5_gcd_resetn", {31'd0, gcd_resetn}, 32'd1);
      @(negedge clock);
      @(negedge clock);
      resetn = 1'b1;
      repeat (3) @(negedge clock);
      force_done = 1'b1;
      @(negedge clock);
      force_done = 1'b0;
      bus_read(2'd2, v);
      check("t5_ctrl", v, 32'h0);
      bus_read(2'd3, v);
      check("t5_result", v, 32'd0);
      bus_read(2'd0, v);
      check("t5_shadowA", v, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               compared, mismatched);
      $finish;
   end

endmodule
